// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux select arbiter.
// Source count, select width, FSM encoding and one-hot decode.
package mux_arb_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [N_SRC-1:0] NO_SRC = '0;

  function automatic logic [N_SRC-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    logic [N_SRC-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Round-robin picker: first eligible request at or after ptr.
// Purely combinational; masked sources are never chosen.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_SRC-1:0] mask,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate eligible requests so bit 0 is the ptr position.
  always_comb begin
    elig = req & ~mask;
    rot  = elig;
    unique case (ptr)
      2'd0: rot = elig;
      2'd1: rot = {elig[0], elig[3:1]};
      2'd2: rot = {elig[1:0], elig[3:2]};
      2'd3: rot = {elig[2:0], elig[3]};
      default: rot = elig;
    endcase
  end

  // Lowest set bit of the rotated vector, mapped back by adding ptr.
  always_comb begin
    off = 2'd0;
    unique case (1'b1)
      rot[0]:                       off = 2'd0;
      (!rot[0] && rot[1]):          off = 2'd1;
      (!(|rot[1:0]) && rot[2]):     off = 2'd2;
      (!(|rot[2:0]) && rot[3]):     off = 2'd3;
      default:                      off = 2'd0;
    endcase
    any = |elig;
    idx = ptr + off;
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Four-source round-robin arbiter driving a 4:1 mux select.
// Grants hold until ack, requester drop, or HOLD_MAX timeout.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic             ack,
  output logic [SEL_W-1:0] s,
  output logic [N_SRC-1:0] gnt,
  output logic             valid,
  output logic             timeout
);

  localparam int CW =
    (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam bit TO_EN = (HOLD_MAX != 0);

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [SEL_W-1:0] s_d;
  logic [N_SRC-1:0] gnt_d;
  logic             valid_d;
  logic             timeout_d;

  logic             in_grant;
  logic             to_hit;
  logic             abandon;
  logic             release_ev;
  logic             to_rel;
  logic [SEL_W-1:0] s_inc;
  logic [SEL_W-1:0] pick_ptr;
  logic [N_SRC-1:0] pick_mask;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  // Release conditions for the grant currently held.
  always_comb begin
    in_grant   = (state_q == GRANT);
    s_inc      = s_q_inc(s);
    to_hit     = TO_EN && (cnt_q == CNT_LAST);
    abandon    = !req[s];
    release_ev = in_grant && (ack || abandon || to_hit);
    to_rel     = in_grant && to_hit && !ack;
    pick_ptr   = in_grant ? s_inc : ptr_q;
    pick_mask  = (in_grant && !ack) ? onehot(s) : NO_SRC;
  end

  function automatic logic [SEL_W-1:0] s_q_inc(
    input logic [SEL_W-1:0] v
  );
    return v + 2'd1;
  endfunction

  rr_pick u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter or stay in GRANT while there is a winner.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) state_d = GRANT;
      end
      GRANT: begin
        if (release_ev && !pick_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs, ptr and hold counter.
  always_comb begin
    s_d       = s;
    gnt_d     = gnt;
    valid_d   = valid;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          s_d     = pick_idx;
          gnt_d   = onehot(pick_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_ev) begin
          ptr_d     = s_inc;
          timeout_d = to_rel;
          if (pick_any) begin
            s_d     = pick_idx;
            gnt_d   = onehot(pick_idx);
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            gnt_d   = NO_SRC;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d   = NO_SRC;
        valid_d = 1'b0;
      end
    endcase
  end

  // Output, pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s       <= '0;
      gnt     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      s       <= s_d;
      gnt     <= gnt_d;
      valid   <= valid_d;
      timeout <= timeout_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed vector table, async
// reset sequence and randomized run against a reference model.
module tb_mux_sel_arbiter;

  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       valid;
  logic       timeout;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       v;
    logic [1:0] s;
    logic [3:0] g;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  // Reference model state (what the outputs should be).
  int m_valid;
  int m_s;
  int m_ptr;
  int m_age;
  int m_to;

  mux_sel_arbiter #(.HOLD_MAX(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .s       (s),
    .gnt     (gnt),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(
    input logic [3:0] r, input logic a,
    input logic v, input logic [1:0] ss,
    input logic [3:0] g, input logic t
  );
    vec_t x;
    x.req = r; x.ack = a; x.v = v;
    x.s = ss; x.g = g; x.to = t;
    vecs.push_back(x);
  endfunction

  task automatic check(
    input string name, input logic v,
    input logic [1:0] ss, input logic [3:0] g,
    input logic t
  );
    n_checks++;
    if (valid !== v || s !== ss || gnt !== g
        || timeout !== t) begin
      n_fail++;
      $display("FAIL %s: got v=%0b s=%0d gnt=%b to=%0b, expected v=%0b s=%0d gnt=%b to=%0b",
               name, valid, s, gnt, timeout, v, ss, g, t);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_s = 0; m_ptr = 0;
    m_age = 0;   m_to = 0;
  endtask

  // One clock of the arbitration rules, stated directly.
  task automatic model_step(input logic [3:0] r, input logic a);
    int excl;
    int found;
    int rel;
    int tmo;
    int k;
    m_to  = 0;
    excl  = -1;
    rel   = 0;
    found = -1;
    if (m_valid == 0) begin
      rel = 1;
    end else begin
      tmo = (H != 0 && m_age == H - 1) ? 1 : 0;
      if (a || !r[m_s] || tmo != 0) begin
        rel   = 1;
        m_to  = (tmo != 0 && !a) ? 1 : 0;
        m_ptr = (m_s + 1) % 4;
        if (!a) excl = m_s;
      end else begin
        m_age++;
      end
    end
    if (rel != 0) begin
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (found < 0 && r[k] && k != excl) found = k;
      end
      if (found >= 0) begin
        m_valid = 1;
        m_s     = found;
        m_age   = 0;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       a;
    logic [3:0] eg;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    req = '0;
    ack = 1'b0;

    // Directed table, starting from reset with ptr=0.
    for (int i = 0; i < 5; i++) add(4'h0, 0, 0, 0, 4'h0, 0);
    add(4'hf, 0, 1, 0, 4'h1, 0);
    add(4'hf, 1, 1, 1, 4'h2, 0);
    add(4'hf, 1, 1, 2, 4'h4, 0);
    add(4'hf, 1, 1, 3, 4'h8, 0);
    add(4'hf, 1, 1, 0, 4'h1, 0);
    add(4'h0, 0, 0, 0, 4'h0, 0);
    add(4'h4, 0, 1, 2, 4'h4, 0);
    add(4'h4, 0, 1, 2, 4'h4, 0);
    add(4'h4, 1, 1, 2, 4'h4, 0);
    add(4'h0, 0, 0, 2, 4'h0, 0);
    add(4'h8, 0, 1, 3, 4'h8, 0);
    add(4'h1, 0, 1, 0, 4'h1, 0);
    add(4'h0, 0, 0, 0, 4'h0, 0);
    add(4'h3, 0, 1, 1, 4'h2, 0);
    for (int i = 0; i < 3; i++) add(4'h3, 0, 1, 1, 4'h2, 0);
    add(4'h3, 0, 1, 0, 4'h1, 1);
    for (int i = 0; i < 3; i++) add(4'h3, 0, 1, 0, 4'h1, 0);
    add(4'h3, 0, 1, 1, 4'h2, 1);
    for (int i = 0; i < 3; i++) add(4'h3, 0, 1, 1, 4'h2, 0);
    add(4'h3, 1, 1, 0, 4'h1, 0);
    add(4'h0, 0, 0, 0, 4'h0, 0);

    #1;
    check("reset", 0, 0, 4'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].req, vecs[i].ack);
      check($sformatf("vec%0d", i), vecs[i].v, vecs[i].s,
            vecs[i].g, vecs[i].to);
    end

    // Async reset mid-grant of source 3 (ptr is 1 here).
    cycle(4'h8, 0);
    check("pre_rst_grant", 1, 3, 4'h8, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 0, 0, 4'h0, 0);
    #2;
    rst = 1'b0;
    cycle(4'ha, 0);
    check("post_rst_grant", 1, 1, 4'h2, 0);
    cycle(4'ha, 1);
    check("post_rst_next", 1, 3, 4'h8, 0);

    // Randomized run against the model.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) r = 4'($urandom);
      a = ($urandom_range(3) == 0);
      cycle(r, a);
      model_step(r, a);
      eg = (m_valid != 0) ? 4'(1 << m_s) : 4'h0;
      check($sformatf("rand%0d", i), m_valid != 0,
            2'(m_s), eg, m_to != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
